// File: rtl/msix_pkg.sv
// Shared definitions for the MSI-X vector engine: FSM encodings, table entry
// layout, message payload type and a width helper.
package msix_pkg;

   // Engine FSM encodings
   localparam int unsigned STATE_W    = 4;
   localparam logic [3:0]  S_IDLE     = 4'd0;
   localparam logic [3:0]  S_ARB      = 4'd1;
   localparam logic [3:0]  S_FETCH0   = 4'd2;
   localparam logic [3:0]  S_FETCH1   = 4'd3;
   localparam logic [3:0]  S_FETCH2   = 4'd4;
   localparam logic [3:0]  S_FETCH3   = 4'd5;
   localparam logic [3:0]  S_FETCH4   = 4'd6;
   localparam logic [3:0]  S_CHECK    = 4'd7;
   localparam logic [3:0]  S_ISSUE    = 4'd8;
   localparam logic [3:0]  S_WAIT_ACK = 4'd9;

   // Table entry layout (byte offsets within a 16-byte entry)
   localparam logic [3:0]  DW_ADDR_LO   = 4'h0;
   localparam logic [3:0]  DW_ADDR_HI   = 4'h4;
   localparam logic [3:0]  DW_DATA      = 4'h8;
   localparam logic [3:0]  DW_CTRL      = 4'hC;
   localparam int unsigned ENTRY_STRIDE = 16;
   localparam int unsigned MASK_BIT     = 0;

   localparam int unsigned MAX_VECTORS = 2048;
   localparam int unsigned VEC_IDX_W   = $clog2(MAX_VECTORS);

   // Message as presented to the PCIe core
   typedef struct packed {
      logic [63:0] address;
      logic [31:0] data;
   } msix_msg_t;

   // $clog2 that never returns 0, so single-entry objects still get a 1-bit index
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_tdp.sv
// True-dual-port block RAM, read-first, 1-cycle registered read on both ports.
// Ports: clk; A side wea/addra/dina/douta; B side web/addrb/dinb/doutb.
// Contents are not reset.
module bram_tdp #(
   parameter int unsigned DATA = 32,
   parameter int unsigned ADDR = 10
) (
   input  logic            clk,
   input  logic            wea,
   input  logic [ADDR-1:0] addra,
   input  logic [DATA-1:0] dina,
   output logic [DATA-1:0] douta,
   input  logic            web,
   input  logic [ADDR-1:0] addrb,
   input  logic [DATA-1:0] dinb,
   output logic [DATA-1:0] doutb
);

   localparam int unsigned DEPTH = 1 << ADDR;

   logic [DATA-1:0] mem [DEPTH];

   // Both ports in one process so the array has a single driver
   always_ff @(posedge clk) begin
      if (wea) mem[addra] <= dina;
      if (web) mem[addrb] <= dinb;
      douta <= mem[addra];
      doutb <= mem[addrb];
   end

endmodule

// File: rtl/msix_vector_engine_rr_arbiter.sv
// Round-robin find-first: returns the first requesting index at or after ptr,
// wrapping to 0. Purely combinational.
// Ports: req (request vector), ptr (search start), grant_c (index), valid_c (any request).
module msix_rr_arbiter import msix_pkg::*; #(
   parameter int unsigned C_NUM_VECTORS = 32,
   localparam int unsigned VW = clog2_min1(C_NUM_VECTORS)
) (
   input  logic [C_NUM_VECTORS-1:0] req,
   input  logic [VW-1:0]            ptr,
   output logic [VW-1:0]            grant_c,
   output logic                     valid_c
);

   logic [VW-1:0] hi_idx_c;
   logic [VW-1:0] lo_idx_c;
   logic          hi_valid_c;

   // Descending scan: the last hit written is the lowest index in each region
   always_comb begin
      hi_idx_c   = '0;
      lo_idx_c   = '0;
      hi_valid_c = 1'b0;
      valid_c    = 1'b0;
      for (int j = C_NUM_VECTORS - 1; j >= 0; j--) begin
         if (req[j]) begin
            valid_c  = 1'b1;
            lo_idx_c = VW'(j);
            if (j >= int'(ptr)) begin
               hi_valid_c = 1'b1;
               hi_idx_c   = VW'(j);
            end
         end
      end
      grant_c = hi_valid_c ? hi_idx_c : lo_idx_c;
   end

endmodule

// File: rtl/msix_vector_engine.sv
// MSI-X table/PBA owner and interrupt issuer for the 7-Series PCIe block.
// Ports: clk/rst (sync, active-high); s_mem_iface_* host table/PBA access with
// 1-cycle read latency; cfg_interrupt_msix_* to/from the PCIe core; irq user
// requests; busy (engine not idle); irq_drop/irq_drop_vector report vectors
// discarded after exhausting retries.
module msix_vector_engine import msix_pkg::*; #(
   parameter int unsigned C_ADDR_WIDTH        = 12,
   parameter int unsigned C_DATA_WIDTH        = 32,
   parameter int unsigned C_NUM_VECTORS       = 32,
   parameter logic [31:0] C_MSIX_TABLE_OFFSET = 32'h0,
   parameter logic [31:0] C_MSIX_PBA_OFFSET   = 32'h800,
   parameter bit          C_IRQ_EDGE          = 1'b1,
   parameter int unsigned C_MAX_RETRIES       = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [C_ADDR_WIDTH-1:0]  s_mem_iface_waddr,
   input  logic [C_ADDR_WIDTH-1:0]  s_mem_iface_raddr,
   input  logic [C_DATA_WIDTH-1:0]  s_mem_iface_wdata,
   input  logic                     s_mem_iface_we_norread,
   output logic [C_DATA_WIDTH-1:0]  s_mem_iface_rdata,
   input  logic [1:0]               cfg_interrupt_msix_enable,
   input  logic [1:0]               cfg_interrupt_msix_mask,
   output logic [63:0]              cfg_interrupt_msix_address,
   output logic [31:0]              cfg_interrupt_msix_data,
   output logic                     cfg_interrupt_msix_int,
   input  logic                     cfg_interrupt_msix_sent,
   input  logic                     cfg_interrupt_msix_fail,
   input  logic [C_NUM_VECTORS-1:0] irq,
   output logic                     busy,
   output logic                     irq_drop,
   output logic [VEC_IDX_W-1:0]     irq_drop_vector
);

   localparam int unsigned VW        = clog2_min1(C_NUM_VECTORS);
   localparam int unsigned TBL_AW    = $clog2(C_NUM_VECTORS * 4);
   localparam int unsigned TBL_BYTES = ENTRY_STRIDE * C_NUM_VECTORS;
   localparam int unsigned PBA_DW    = (C_NUM_VECTORS + 31) / 32;
   localparam int unsigned PBA_BITS  = PBA_DW * 32;
   localparam int unsigned PBA_BYTES = PBA_DW * 4;
   localparam int unsigned RW        = clog2_min1(C_MAX_RETRIES + 1);
   localparam logic [C_NUM_VECTORS-1:0] VEC_ONE = C_NUM_VECTORS'(1);

   logic [STATE_W-1:0]       state_q, state_d;
   logic [VW-1:0]            vec_q, vec_d;
   logic [VW-1:0]            rr_q, rr_d;
   logic [RW-1:0]            retry_q, retry_d;
   msix_msg_t                ent_q, ent_d;
   logic                     ent_mask_q, ent_mask_d;
   msix_msg_t                msg_q, msg_d;
   logic                     int_q, int_d;
   logic                     drop_q, drop_d;
   logic [VEC_IDX_W-1:0]     drop_vec_q, drop_vec_d;
   logic                     busy_q;
   logic [C_NUM_VECTORS-1:0] pending_q;
   logic [C_NUM_VECTORS-1:0] irq_q;
   logic                     clr_en_c;

   logic [VW-1:0]            arb_grant_c;
   logic                     arb_valid_c;
   logic [VW-1:0]            vec_next_c;
   logic [1:0]               fetch_dw_c;
   logic [C_DATA_WIDTH-1:0]  douta, doutb;

   logic [31:0]              wr_off_c, rd_off_c, pba_off_c;
   logic                     wr_tbl_hit_c, rd_tbl_hit_c, rd_pba_hit_c;
   logic [TBL_AW-1:0]        host_addr_c;
   logic [PBA_BITS-1:0]      pend_pad_c;
   logic [31:0]              pba_word_c;
   logic                     rd_tbl_q;
   logic [31:0]              pba_rdata_q;
   logic                     unused_cfg_c;

   assign unused_cfg_c = ^{cfg_interrupt_msix_enable[1], cfg_interrupt_msix_mask[1]};

   // Host address decode; subtraction wraps so below-base addresses miss
   assign wr_off_c     = 32'(s_mem_iface_waddr) - C_MSIX_TABLE_OFFSET;
   assign rd_off_c     = 32'(s_mem_iface_raddr) - C_MSIX_TABLE_OFFSET;
   assign pba_off_c    = 32'(s_mem_iface_raddr) - C_MSIX_PBA_OFFSET;
   assign wr_tbl_hit_c = s_mem_iface_we_norread && (wr_off_c < TBL_BYTES);
   assign rd_tbl_hit_c = !s_mem_iface_we_norread && (rd_off_c < TBL_BYTES);
   assign rd_pba_hit_c = !s_mem_iface_we_norread && (pba_off_c < PBA_BYTES);
   assign host_addr_c  = s_mem_iface_we_norread ? wr_off_c[TBL_AW+1:2] : rd_off_c[TBL_AW+1:2];

   // PBA word select; bits beyond C_NUM_VECTORS read as 0
   assign pend_pad_c = PBA_BITS'(pending_q);
   always_comb begin
      pba_word_c = '0;
      for (int k = 0; k < int'(PBA_DW); k++) begin
         if (pba_off_c[31:2] == 30'(k)) pba_word_c = pend_pad_c[k*32 +: 32];
      end
   end

   // Engine fetch address: DW index follows the FETCH state
   always_comb begin
      case (state_q)
         S_FETCH1: fetch_dw_c = DW_ADDR_HI[3:2];
         S_FETCH2: fetch_dw_c = DW_DATA[3:2];
         S_FETCH3: fetch_dw_c = DW_CTRL[3:2];
         default:  fetch_dw_c = DW_ADDR_LO[3:2];
      endcase
   end

   bram_tdp #(
      .DATA (C_DATA_WIDTH),
      .ADDR (TBL_AW)
   ) u_table (
      .clk   (clk),
      .wea   (1'b0),
      .addra (TBL_AW'({vec_q, fetch_dw_c})),
      .dina  ('0),
      .douta (douta),
      .web   (wr_tbl_hit_c),
      .addrb (host_addr_c),
      .dinb  (s_mem_iface_wdata),
      .doutb (doutb)
   );

   msix_rr_arbiter #(
      .C_NUM_VECTORS (C_NUM_VECTORS)
   ) u_arb (
      .req     (pending_q),
      .ptr     (rr_q),
      .grant_c (arb_grant_c),
      .valid_c (arb_valid_c)
   );

   assign vec_next_c = (32'(vec_q) == C_NUM_VECTORS - 1) ? '0 : vec_q + VW'(1);

   // Engine next-state and registered-output values
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      rr_d       = rr_q;
      retry_d    = retry_q;
      ent_d      = ent_q;
      ent_mask_d = ent_mask_q;
      msg_d      = msg_q;
      int_d      = 1'b0;
      drop_d     = 1'b0;
      drop_vec_d = drop_vec_q;
      clr_en_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_interrupt_msix_enable[0] && !cfg_interrupt_msix_mask[0] && (|pending_q))
               state_d = S_ARB;
         end
         S_ARB: begin
            if (arb_valid_c) begin
               vec_d   = arb_grant_c;
               state_d = S_FETCH0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH0: state_d = S_FETCH1;
         S_FETCH1: begin
            ent_d.address[31:0] = douta;
            state_d = S_FETCH2;
         end
         S_FETCH2: begin
            ent_d.address[63:32] = douta;
            state_d = S_FETCH3;
         end
         S_FETCH3: begin
            ent_d.data = douta;
            state_d    = S_FETCH4;
         end
         S_FETCH4: begin
            ent_mask_d = douta[MASK_BIT];
            state_d    = S_CHECK;
         end
         S_CHECK: begin
            // Masked entries keep their pending bit and yield to the next vector
            if (ent_mask_q || cfg_interrupt_msix_mask[0] || !cfg_interrupt_msix_enable[0]) begin
               rr_d    = vec_next_c;
               state_d = S_IDLE;
            end else begin
               msg_d   = ent_q;
               int_d   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (cfg_interrupt_msix_sent) begin
               clr_en_c = 1'b1;
               retry_d  = '0;
               rr_d     = vec_next_c;
               state_d  = S_IDLE;
            end else if (cfg_interrupt_msix_fail) begin
               if (32'(retry_q) < C_MAX_RETRIES) begin
                  retry_d = retry_q + RW'(1);
                  int_d   = 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  clr_en_c   = 1'b1;
                  drop_d     = 1'b1;
                  drop_vec_d = VEC_IDX_W'(vec_q);
                  retry_d    = '0;
                  rr_d       = vec_next_c;
                  state_d    = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, pending and output registers; set beats clear on the same vector
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         rr_q        <= '0;
         retry_q     <= '0;
         ent_q       <= '0;
         ent_mask_q  <= 1'b0;
         msg_q       <= '0;
         int_q       <= 1'b0;
         drop_q      <= 1'b0;
         drop_vec_q  <= '0;
         busy_q      <= 1'b0;
         pending_q   <= '0;
         irq_q       <= '0;
         rd_tbl_q    <= 1'b0;
         pba_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         rr_q        <= rr_d;
         retry_q     <= retry_d;
         ent_q       <= ent_d;
         ent_mask_q  <= ent_mask_d;
         msg_q       <= msg_d;
         int_q       <= int_d;
         drop_q      <= drop_d;
         drop_vec_q  <= drop_vec_d;
         busy_q      <= (state_d != S_IDLE);
         irq_q       <= irq;
         pending_q   <= (pending_q & ~(clr_en_c ? (VEC_ONE << vec_q) : '0))
                        | (C_IRQ_EDGE ? (irq & ~irq_q) : irq);
         rd_tbl_q    <= rd_tbl_hit_c;
         pba_rdata_q <= rd_pba_hit_c ? pba_word_c : '0;
      end
   end

   // Table and PBA regions never overlap, so pba_rdata_q is 0 on table reads
   assign s_mem_iface_rdata          = rd_tbl_q ? doutb : pba_rdata_q;
   assign cfg_interrupt_msix_address = msg_q.address;
   assign cfg_interrupt_msix_data    = msg_q.data;
   assign cfg_interrupt_msix_int     = int_q;
   assign busy                       = busy_q;
   assign irq_drop                   = drop_q;
   assign irq_drop_vector            = drop_vec_q;

endmodule

// File: tb/tb_msix_vector_engine.sv
// Scoreboard bench for msix_vector_engine: stimulus pushes expected messages
// and drops; a negedge monitor pops and compares on each int / irq_drop strobe.
module tb_msix_vector_engine;

   localparam int unsigned N = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [11:0]   waddr, raddr;
   logic [31:0]   wdata, rdata;
   logic          we;
   logic [1:0]    enable, mask;
   logic [63:0]   msix_address;
   logic [31:0]   msix_data;
   logic          msix_int, sent, fail;
   logic [N-1:0]  irq;
   logic          busy, irq_drop;
   logic [10:0]   irq_drop_vector;

   typedef struct packed {
      logic [63:0] a;
      logic [31:0] d;
   } msg_t;

   msg_t        exp_q[$];
   logic [10:0] drop_q[$];
   int checks = 0;
   int errors = 0;
   int n_int = 0;
   int n_drop = 0;
   int resp_delay = 4;
   bit resp_off = 1'b0;
   int fail_target = 0;
   int fails_given = 0;

   always #5 clk = ~clk;

   msix_vector_engine dut (
      .clk                        (clk),
      .rst                        (rst),
      .s_mem_iface_waddr          (waddr),
      .s_mem_iface_raddr          (raddr),
      .s_mem_iface_wdata          (wdata),
      .s_mem_iface_we_norread     (we),
      .s_mem_iface_rdata          (rdata),
      .cfg_interrupt_msix_enable  (enable),
      .cfg_interrupt_msix_mask    (mask),
      .cfg_interrupt_msix_address (msix_address),
      .cfg_interrupt_msix_data    (msix_data),
      .cfg_interrupt_msix_int     (msix_int),
      .cfg_interrupt_msix_sent    (sent),
      .cfg_interrupt_msix_fail    (fail),
      .irq                        (irq),
      .busy                       (busy),
      .irq_drop                   (irq_drop),
      .irq_drop_vector            (irq_drop_vector)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic msg_t mk(input int idx);
      return {32'h0, 32'hFEE0_0000 + 32'(idx * 16), 32'h100 + 32'(idx)};
   endfunction

   task automatic host_write(input int a, input logic [31:0] d);
      waddr = 12'(a);
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic host_read(input int a, output logic [31:0] d);
      raddr = 12'(a);
      we    = 1'b0;
      @(posedge clk);
      #1;
      d = rdata;
   endtask

   task automatic prog(input int idx, input msg_t m, input logic [31:0] ctrl);
      host_write(idx * 16 + 0,  m.a[31:0]);
      host_write(idx * 16 + 4,  m.a[63:32]);
      host_write(idx * 16 + 8,  m.d);
      host_write(idx * 16 + 12, ctrl);
   endtask

   task automatic pulse_irq(input logic [N-1:0] v);
      irq = v;
      @(posedge clk);
      #1;
      irq = '0;
   endtask

   // Bounded wait for all expected traffic to be seen and the engine to go idle
   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || drop_q.size() != 0 || busy !== 1'b0) && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (k >= budget) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, %0d msgs and %0d drops outstanding",
                  name, k, exp_q.size(), drop_q.size());
      end
   endtask

   // Monitor: compare every issue strobe and drop pulse against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (msix_int === 1'b1) begin
            n_int++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_int: got addr %h data %h, expected no message", msix_address, msix_data);
            end else begin
               msg_t e;
               e = exp_q.pop_front();
               check("int_message", {msix_address, msix_data}, e);
            end
         end
         if (irq_drop === 1'b1) begin
            n_drop++;
            if (drop_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_drop: got vector %0d, expected no drop", irq_drop_vector);
            end else begin
               logic [10:0] dv;
               dv = drop_q.pop_front();
               check("drop_vector", 96'(irq_drop_vector), 96'(dv));
            end
         end
      end
   end

   // PCIe core model: answers each strobe with fail (while budget remains) or sent
   initial begin
      sent = 1'b0;
      fail = 1'b0;
      forever begin
         @(negedge clk);
         if (msix_int === 1'b1 && !resp_off) begin
            repeat (resp_delay) @(posedge clk);
            #1;
            if (fails_given < fail_target) begin
               fail = 1'b1;
               fails_given++;
            end else begin
               sent = 1'b1;
            end
            @(posedge clk);
            #1;
            sent = 1'b0;
            fail = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int k;
      int base;
      bit got;
      msg_t m;

      rst = 1'b1; we = 1'b0; waddr = '0; raddr = '0; wdata = '0;
      enable = 2'b00; mask = 2'b00; irq = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_int",   96'(msix_int), 96'(0));
      check("rst_busy",  96'(busy), 96'(0));
      check("rst_drop",  96'(irq_drop), 96'(0));
      check("rst_msg",   {msix_address, msix_data}, 96'(0));
      check("rst_rdata", 96'(rdata), 96'(0));
      rst = 1'b0;

      // Basic issue of vector 5 with latency and PBA observation
      m = {64'h0000_0001_FEE0_0000, 32'h45};
      prog(5, m, 32'h0);
      enable = 2'b01;
      resp_delay = 4;
      exp_q.push_back(m);
      irq[5] = 1'b1;
      k = 0;
      got = 1'b0;
      while (!got && k < 30) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) irq[5] = 1'b0;
         if (msix_int === 1'b1) got = 1'b1;
      end
      check("issue_latency", 96'(k - 1), 96'(8));
      host_read(32'h800, rd);
      check("pba_pending_5", 96'(rd), 96'(32'h20));
      wait_done("t1_done", 100);
      host_read(32'h800, rd);
      check("pba_clear_5", 96'(rd), 96'(0));
      host_read(32'h58, rd);
      check("table_read_5", 96'(rd), 96'(32'h45));

      // Masked vector 3 stays pending until unmasked
      m = {64'h0000_0000_FEE0_1000, 32'h33};
      prog(3, m, 32'h1);
      base = n_int;
      pulse_irq(N'(1) << 3);
      repeat (40) @(posedge clk);
      #1;
      check("masked_no_int", 96'(n_int), 96'(base));
      host_read(32'h800, rd);
      check("pba_masked_3", 96'(rd), 96'(32'h8));
      exp_q.push_back(m);
      host_write(32'h3C, 32'h0);
      wait_done("t2_done", 200);
      host_read(32'h800, rd);
      check("pba_clear_3", 96'(rd), 96'(0));

      // Round-robin order from rr_ptr=0, then re-pend 2 while 7 is in service
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      prog(2, mk(2), 32'h0);
      prog(7, mk(7), 32'h0);
      prog(30, mk(30), 32'h0);
      exp_q.push_back(mk(2));
      exp_q.push_back(mk(7));
      exp_q.push_back(mk(30));
      exp_q.push_back(mk(2));
      base = n_int;
      pulse_irq((N'(1) << 2) | (N'(1) << 7) | (N'(1) << 30));
      k = 0;
      while (n_int < base + 2 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("rr_second_issue_seen", 96'(n_int), 96'(base + 2));
      pulse_irq(N'(1) << 2);
      wait_done("t3_done", 400);

      // Four failures: three retries, then a drop of vector 9
      prog(9, mk(9), 32'h0);
      fail_target = fails_given + 4;
      base = n_drop;
      repeat (4) exp_q.push_back(mk(9));
      drop_q.push_back(11'd9);
      pulse_irq(N'(1) << 9);
      wait_done("t4_done", 400);
      check("drop_count", 96'(n_drop), 96'(base + 1));
      host_read(32'h800, rd);
      check("pba_after_drop", 96'(rd), 96'(0));

      // PBA writes ignored, unmapped reads 0, held level gives one edge
      host_write(32'h800, 32'hFFFF_FFFF);
      host_read(32'h800, rd);
      check("pba_write_ignored", 96'(rd), 96'(0));
      host_read(32'h400, rd);
      check("unmapped_read", 96'(rd), 96'(0));
      prog(0, mk(0), 32'h0);
      base = n_int;
      exp_q.push_back(mk(0));
      irq[0] = 1'b1;
      wait_done("t5_done", 200);
      repeat (40) @(posedge clk);
      #1;
      check("held_irq_single_int", 96'(n_int), 96'(base + 1));
      irq[0] = 1'b0;

      // Reset while waiting for the acknowledge
      prog(12, mk(12), 32'h0);
      resp_off = 1'b1;
      exp_q.push_back(mk(12));
      pulse_irq(N'(1) << 12);
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("busy_in_wait", 96'(busy), 96'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_wait_int",  96'(msix_int), 96'(0));
      check("rst_wait_busy", 96'(busy), 96'(0));
      check("rst_wait_msg",  {msix_address, msix_data}, 96'(0));
      rst = 1'b0;
      host_read(32'h800, rd);
      check("pba_after_rst", 96'(rd), 96'(0));
      host_read(12 * 16 + 8, rd);
      check("table_kept_12", 96'(rd), 96'(32'h10C));
      host_read(32'h50, rd);
      check("table_kept_5", 96'(rd), 96'(32'hFEE0_0000));
      resp_off = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("sb_drained", 96'(exp_q.size() + drop_q.size()), 96'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
